// File: rtl/tinsel_acc_pkg.sv
// Shared Tinsel accelerator types: network address and flit layout.
// Widths mirror the config.v values used by the mailbox mesh.
package tinsel_acc_pkg;

    localparam int MESH_X_BITS = 3;
    localparam int MESH_Y_BITS = 3;
    localparam int LOG_THREADS_PER_MBOX = 6;
    localparam int FLIT_PAYLOAD_BITS = 32;
    localparam int TINSEL_MAX_FLITS_PER_MSG = 4;

    typedef struct packed {
        logic [MESH_Y_BITS-1:0]          y;
        logic [MESH_X_BITS-1:0]          x;
        logic [LOG_THREADS_PER_MBOX-1:0] thread;
    } NetAddr;

    typedef struct packed {
        NetAddr                       dest;
        logic [FLIT_PAYLOAD_BITS-1:0] payload;
        logic                         notFinalFlit;
        logic                         isIdleToken;
    } Flit;

endpackage

// File: rtl/acc_flit_ram.sv
// Flit storage: synchronous write on the BSV-side edge,
// asynchronous read of the head entry.
module acc_flit_ram
    import tinsel_acc_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  Flit                      wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output Flit                      rdata
);

    Flit mem [DEPTH];

    always_ff @(negedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/acc_msg_buffer.sv
// Store-and-forward flit buffer: the head flit is offered downstream
// only once its whole message is held locally.
module acc_msg_buffer
    import tinsel_acc_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int MAX_MSG_FLITS = TINSEL_MAX_FLITS_PER_MSG
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  Flit                        in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output Flit                        out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] msg_count,
    output logic                       overlong_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = (MAX_MSG_FLITS > 1) ? $clog2(MAX_MSG_FLITS) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [SW-1:0] SEG_LAST = SW'(MAX_MSG_FLITS - 1);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] flit_count;
    logic [SW-1:0] seg_len;

    Flit  wr_flit;
    logic push;
    logic pop;
    logic overlong;
    logic push_final;
    logic pop_final;

    assign in_ready  = rst_n && (flit_count != FULL);
    assign out_valid = rst_n && (msg_count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // A flit that would overrun the longest legal message closes it.
    assign overlong = in_data.notFinalFlit && (seg_len == SEG_LAST);

    always_comb begin
        wr_flit = in_data;
        if (overlong) wr_flit.notFinalFlit = 1'b0;
    end

    assign push_final = push && !wr_flit.notFinalFlit;
    assign pop_final  = pop && !out_data.notFinalFlit;

    acc_flit_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (push),
        .waddr(wr_ptr),
        .wdata(wr_flit),
        .raddr(rd_ptr),
        .rdata(out_data)
    );

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            flit_count   <= '0;
            msg_count    <= '0;
            seg_len      <= '0;
            overlong_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);

            unique case ({push, pop})
                2'b10:   flit_count <= flit_count + CW'(1);
                2'b01:   flit_count <= flit_count - CW'(1);
                default: flit_count <= flit_count;
            endcase

            unique case ({push_final, pop_final})
                2'b10:   msg_count <= msg_count + CW'(1);
                2'b01:   msg_count <= msg_count - CW'(1);
                default: msg_count <= msg_count;
            endcase

            if (push) seg_len <= push_final ? '0 : seg_len + SW'(1);
            if (push && overlong) overlong_err <= 1'b1;
        end
    end

endmodule
